// File: rtl/button_conditioner.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Brief    : Per-channel conditioner for active-low push buttons. Each channel
//            has a 2-flop synchroniser, a consecutive-sample debounce filter,
//            registered one-cycle press/release pulses, and an optional
//            auto-repeat of the press pulse while the button stays held.
// Revision : 1.0 - initial release
// ============================================================================
module button_conditioner #(
  parameter int NUM_CH          = 2,
  parameter int CNT_W           = 20,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [NUM_CH-1:0] btn_n,
  input  logic [NUM_CH-1:0] repeat_en,
  output logic [NUM_CH-1:0] level,
  output logic [NUM_CH-1:0] press_pulse,
  output logic [NUM_CH-1:0] release_pulse
);

  // Counters are widened past CNT_W when a terminal count would not fit, so
  // a compare value can never be silently truncated (the default repeat
  // delay of 25M needs 25 bits).
  localparam int c_rep_max = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int c_dcnt_w  = (CNT_W > $clog2(DEBOUNCE_CYCLES)) ? CNT_W : $clog2(DEBOUNCE_CYCLES);
  localparam int c_rcnt_w  = (CNT_W > $clog2(c_rep_max)) ? CNT_W : $clog2(c_rep_max);

  localparam logic [c_dcnt_w-1:0] c_deb_last    = c_dcnt_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_rcnt_w-1:0] c_delay_last  = c_rcnt_w'(REPEAT_DELAY - 1);
  localparam logic [c_rcnt_w-1:0] c_period_last = c_rcnt_w'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESSED   = 2'd1,
    ST_REPEATING = 2'd2
  } state_t;

  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_ch
      logic                r_s1;
      logic                r_s2;
      logic                r_stable;
      logic [c_dcnt_w-1:0] r_dcnt;
      logic                w_diff;
      logic                w_accept;
      logic                w_acc_press;
      logic                w_acc_release;

      state_t              r_state;
      state_t              w_state_nxt;
      logic [c_rcnt_w-1:0] r_rcnt;
      logic [c_rcnt_w-1:0] w_rcnt_nxt;
      logic                w_press_nxt;
      logic                w_release_nxt;
      logic                r_level;
      logic                r_press;
      logic                r_release;

      // Two-flop synchroniser for the asynchronous raw button; idles released.
      always_ff @(posedge Clk) begin
        if (!Reset) begin
          r_s1 <= 1'b1;
          r_s2 <= 1'b1;
        end else begin
          r_s1 <= btn_n[i];
          r_s2 <= r_s1;
        end
      end

      // A change is accepted on the DEBOUNCE_CYCLES-th consecutive differing
      // sample; this is combinational so level/pulses land on the same edge
      // as the stable state update.
      assign w_diff        = (r_s2 != r_stable);
      assign w_accept      = w_diff && (r_dcnt == c_deb_last);
      assign w_acc_press   = w_accept && !r_s2;
      assign w_acc_release = w_accept &&  r_s2;

      // Debounce filter: any sample agreeing with the stable state restarts it.
      always_ff @(posedge Clk) begin
        if (!Reset) begin
          r_stable <= 1'b1;
          r_dcnt   <= '0;
        end else if (!w_diff) begin
          r_dcnt   <= '0;
        end else if (w_accept) begin
          r_stable <= r_s2;
          r_dcnt   <= '0;
        end else begin
          r_dcnt   <= r_dcnt + 1'b1;
        end
      end

      // Press/repeat FSM next state; release is tested first so it always
      // wins over a coincident repeat pulse.
      always_comb begin
        w_state_nxt   = r_state;
        w_rcnt_nxt    = r_rcnt;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
          ST_IDLE: begin
            w_rcnt_nxt = '0;
            if (w_acc_press) begin
              w_state_nxt = ST_PRESSED;
              w_press_nxt = 1'b1;
            end
          end
          ST_PRESSED: begin
            if (w_acc_release) begin
              w_state_nxt   = ST_IDLE;
              w_release_nxt = 1'b1;
              w_rcnt_nxt    = '0;
            end else if (!repeat_en[i]) begin
              w_rcnt_nxt = '0;
            end else if (r_rcnt == c_delay_last) begin
              w_state_nxt = ST_REPEATING;
              w_press_nxt = 1'b1;
              w_rcnt_nxt  = '0;
            end else begin
              w_rcnt_nxt = r_rcnt + 1'b1;
            end
          end
          ST_REPEATING: begin
            if (w_acc_release) begin
              w_state_nxt   = ST_IDLE;
              w_release_nxt = 1'b1;
              w_rcnt_nxt    = '0;
            end else if (!repeat_en[i]) begin
              w_state_nxt = ST_PRESSED;
              w_rcnt_nxt  = '0;
            end else if (r_rcnt == c_period_last) begin
              w_press_nxt = 1'b1;
              w_rcnt_nxt  = '0;
            end else begin
              w_rcnt_nxt = r_rcnt + 1'b1;
            end
          end
          default: begin
            w_state_nxt = ST_IDLE;
            w_rcnt_nxt  = '0;
          end
        endcase
      end

      // FSM state register plus registered level and pulse outputs.
      always_ff @(posedge Clk) begin
        if (!Reset) begin
          r_state   <= ST_IDLE;
          r_rcnt    <= '0;
          r_level   <= 1'b0;
          r_press   <= 1'b0;
          r_release <= 1'b0;
        end else begin
          r_state   <= w_state_nxt;
          r_rcnt    <= w_rcnt_nxt;
          r_level   <= (w_state_nxt != ST_IDLE);
          r_press   <= w_press_nxt;
          r_release <= w_release_nxt;
        end
      end

      assign level[i]         = r_level;
      assign press_pulse[i]   = r_press;
      assign release_pulse[i] = r_release;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_button_conditioner
// Brief    : Scoreboard bench for button_conditioner. The driver pushes the
//            expected outputs of each edge from an edge-distance reference
//            model; a monitor pops and compares after every rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

  localparam int NCH = 2;
  localparam int DEB = 4;
  localparam int RD  = 8;
  localparam int RP  = 3;

  logic           Clk;
  logic           Reset;
  logic [NCH-1:0] btn_n;
  logic [NCH-1:0] repeat_en;
  logic [NCH-1:0] level;
  logic [NCH-1:0] press_pulse;
  logic [NCH-1:0] release_pulse;

  button_conditioner #(
    .NUM_CH          (NCH),
    .CNT_W           (8),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .btn_n         (btn_n),
    .repeat_en     (repeat_en),
    .level         (level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int             e;
    logic [NCH-1:0] lvl;
    logic [NCH-1:0] prs;
    logic [NCH-1:0] rel;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;
  int ecount   = 0;

  int press_cnt[NCH];
  int rel_cnt[NCH];
  int last_press[NCH];
  int last_rel[NCH];

  // Reference model state: raw samples delayed two edges, a window of the
  // last DEB pressed/released samples, accepted held state, and a repeat
  // mode with the edge from which the next repeat interval is measured.
  logic [NCH-1:0] m_d1, m_d2;
  logic [DEB-1:0] m_win[NCH];
  int             m_fill[NCH];
  logic           m_held[NCH];
  int             m_mode[NCH];   // 0 idle, 1 held, 2 repeating
  int             m_anchor[NCH];

  task automatic model_edge(input logic rst_n, input logic [NCH-1:0] b, input logic [NCH-1:0] r);
    exp_t           x;
    logic [NCH-1:0] samp;
    logic           acc;
    x.e   = ecount;
    x.lvl = '0;
    x.prs = '0;
    x.rel = '0;
    if (!rst_n) begin
      m_d1 = '1;
      m_d2 = '1;
      for (int c = 0; c < NCH; c++) begin
        m_win[c] = '0; m_fill[c] = 0; m_held[c] = 1'b0;
        m_mode[c] = 0; m_anchor[c] = 0;
      end
    end else begin
      samp = m_d2;
      m_d2 = m_d1;
      m_d1 = b;
      for (int c = 0; c < NCH; c++) begin
        m_win[c] = {m_win[c][DEB-2:0], ~samp[c]};
        if (m_fill[c] < DEB) m_fill[c]++;
        acc = (m_fill[c] == DEB) &&
              (m_held[c] ? (m_win[c] == '0) : (m_win[c] == '1));
        if (acc) begin
          m_held[c] = ~m_held[c];
          m_fill[c] = 0;
        end
        if (acc && !m_held[c]) begin
          x.rel[c] = 1'b1;
          m_mode[c] = 0;
        end else if (acc) begin
          x.prs[c] = 1'b1;
          m_mode[c] = 1;
          m_anchor[c] = ecount;
        end else if (m_mode[c] == 1) begin
          if (!r[c]) m_anchor[c] = ecount;
          else if (ecount - m_anchor[c] == RD) begin
            x.prs[c] = 1'b1; m_mode[c] = 2; m_anchor[c] = ecount;
          end
        end else if (m_mode[c] == 2) begin
          if (!r[c]) begin
            m_mode[c] = 1; m_anchor[c] = ecount;
          end else if (ecount - m_anchor[c] == RP) begin
            x.prs[c] = 1'b1; m_anchor[c] = ecount;
          end
        end
        x.lvl[c] = (m_mode[c] != 0);
      end
    end
    sb.push_back(x);
  endtask

  // Drive inputs for the next rising edge and record its expected outputs.
  task automatic step(input logic rst_n, input logic [NCH-1:0] b, input logic [NCH-1:0] r);
    @(negedge Clk);
    Reset     = rst_n;
    btn_n     = b;
    repeat_en = r;
    model_edge(rst_n, b, r);
    ecount++;
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, got, want);
  endtask

  // Monitor: compare every edge's outputs against the scoreboard head.
  initial begin
    for (int c = 0; c < NCH; c++) begin
      press_cnt[c] = 0; rel_cnt[c] = 0; last_press[c] = -1; last_rel[c] = -1;
    end
    forever begin
      @(posedge Clk);
      #1;
      if (sb.size() > 0) begin
        exp_t x;
        x = sb.pop_front();
        n_checks++;
        if ({level, press_pulse, release_pulse} === {x.lvl, x.prs, x.rel}) n_pass++;
        else $display("FAIL outputs edge %0d: got level=%b press=%b release=%b, want level=%b press=%b release=%b",
                      x.e, level, press_pulse, release_pulse, x.lvl, x.prs, x.rel);
        for (int c = 0; c < NCH; c++) begin
          if (press_pulse[c] === 1'b1)   begin press_cnt[c]++; last_press[c] = x.e; end
          if (release_pulse[c] === 1'b1) begin rel_cnt[c]++;   last_rel[c]   = x.e; end
        end
      end
    end
  end

  // Stimulus: directed scenarios, then randomized traffic.
  initial begin
    int             t0;
    int             p0, p1, r1;
    logic [NCH-1:0] hold;
    logic [NCH-1:0] ren;
    logic [NCH-1:0] g;
    Reset = 1'b0; btn_n = '1; repeat_en = '0;
    m_d1 = '1; m_d2 = '1;
    for (int c = 0; c < NCH; c++) begin
      m_win[c] = '0; m_fill[c] = 0; m_held[c] = 1'b0; m_mode[c] = 0; m_anchor[c] = 0;
    end

    // Reset with buttons released, then idle.
    step(1'b0, 2'b11, 2'b00);
    step(1'b0, 2'b11, 2'b00);
    for (int k = 0; k < 3; k++) step(1'b1, 2'b11, 2'b00);

    // Clean press and release of ch0.
    t0 = ecount; p1 = press_cnt[1];
    for (int k = 0; k < 10; k++) step(1'b1, 2'b10, 2'b00);
    for (int k = 0; k < 8; k++)  step(1'b1, 2'b11, 2'b00);
    check_int("ch0_press_edge", last_press[0], t0 + DEB + 1);
    check_int("ch0_release_edge", last_rel[0], t0 + 10 + DEB + 1);
    check_int("ch1_no_press", press_cnt[1] - p1, 0);

    // Bounce shorter than the filter on ch0.
    p0 = press_cnt[0];
    for (int k = 0; k < 3; k++) step(1'b1, 2'b10, 2'b00);
    step(1'b1, 2'b11, 2'b00);
    for (int k = 0; k < 2; k++) step(1'b1, 2'b10, 2'b00);
    for (int k = 0; k < 8; k++) step(1'b1, 2'b11, 2'b00);
    check_int("bounce_no_press", press_cnt[0] - p0, 0);

    // Held ch1 with auto-repeat, release suppresses a coincident repeat.
    t0 = ecount; p1 = press_cnt[1]; r1 = rel_cnt[1];
    for (int k = 0; k < 20; k++) step(1'b1, 2'b01, 2'b10);
    for (int k = 0; k < 10; k++) step(1'b1, 2'b11, 2'b10);
    check_int("ch1_repeat_count", press_cnt[1] - p1, 5);
    check_int("ch1_last_repeat_edge", last_press[1], t0 + 22);
    check_int("ch1_release_count", rel_cnt[1] - r1, 1);
    check_int("ch1_release_edge", last_rel[1], t0 + 25);

    // Held ch0, repeat enable dropped after first repeat and raised again.
    t0 = ecount; p0 = press_cnt[0];
    for (int k = 0; k < 32; k++)
      step(1'b1, 2'b10, (k < 14 || k >= 20) ? 2'b01 : 2'b00);
    check_int("ch0_repeat_count", press_cnt[0] - p0, 4);

    // Reset mid-repeat with ch0 held; press re-detected after deassert.
    t0 = ecount;
    step(1'b0, 2'b10, 2'b01);
    for (int k = 0; k < 10; k++) step(1'b1, 2'b10, 2'b01);
    check_int("ch0_press_after_reset", last_press[0], t0 + DEB + 2);
    for (int k = 0; k < 8; k++) step(1'b1, 2'b11, 2'b00);

    // Randomized buttons, glitches, repeat enables and rare resets.
    hold = '1; ren = '0;
    for (int k = 0; k < 700; k++) begin
      g = '0;
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(11) == 0) hold[c] = ~hold[c];
        if ($urandom_range(19) == 0) g[c] = 1'b1;
        if ($urandom_range(39) == 0) ren[c] = ~ren[c];
      end
      step(($urandom_range(299) == 0) ? 1'b0 : 1'b1, hold ^ g, ren);
    end
    for (int k = 0; k < 10; k++) step(1'b1, 2'b11, 2'b00);

    @(posedge Clk);
    #2;
    check_int("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
